// File: rtl/gfcm_pkg.sv
// Shared types and helpers for the gfcm_n glitch-free clock mux.
package gfcm_pkg;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      DIS_WAIT,
      EN_WAIT
   } gfcm_state_e;

   localparam int GFCM_DEFAULT_TIMEOUT = 1024;

   // Width of an index into n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gfcm_chan.sv
// One channel of the glitch-free clock mux: enable synchroniser into clk_in,
// falling-edge gate flop, clock AND gate and acknowledge synchroniser back to clk1.
module gfcm_chan #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk1,
   input  logic reset,
   input  logic clk_in,
   input  logic en_req,
   output logic en_ack,
   output logic gated_clk
);

   logic [SYNC_STAGES-1:0] fwd_q;
   logic                   en_gate_q;
   logic [SYNC_STAGES-1:0] ack_q;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         fwd_q <= '0;
      end else begin
         fwd_q <= {fwd_q[SYNC_STAGES-2:0], en_req};
      end
   end

   // The gate only changes while clk_in is low, so no high phase is ever cut short.
   always_ff @(negedge clk_in or posedge reset) begin
      if (reset) begin
         en_gate_q <= 1'b0;
      end else begin
         en_gate_q <= fwd_q[SYNC_STAGES-1];
      end
   end

   assign gated_clk = clk_in & en_gate_q;

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         ack_q <= '0;
      end else begin
         ack_q <= {ack_q[SYNC_STAGES-2:0], en_gate_q};
      end
   end

   assign en_ack = ack_q[SYNC_STAGES-1];

endmodule

// File: rtl/gfcm_n.sv
// N-input glitch-free clock mux with break-before-make switching requested from clk1.
// Define GFCM_TIMEOUT_EN to add per-phase timeouts and the sel_timeout pulse output.
module gfcm_n
   import gfcm_pkg::*;
#(
   parameter int  NUM_CLK        = 4,
   parameter int  SYNC_STAGES    = 2,
   parameter int  RESET_SEL      = 0,
   parameter int  TIMEOUT_CYCLES = GFCM_DEFAULT_TIMEOUT,
   localparam int SEL_W          = clog2_min1(NUM_CLK)
) (
   input  logic               clk1,
   input  logic               reset,
   input  logic [NUM_CLK-1:0] clk_in,
   input  logic               sel_valid,
   input  logic [SEL_W-1:0]   sel_data,
   output logic               sel_ready,
   output logic               sel_err,
   output logic [SEL_W-1:0]   active_sel,
   output logic               active_valid,
   output logic               busy,
`ifdef GFCM_TIMEOUT_EN
   output logic               sel_timeout,
`endif
   output logic               outclk
);

   localparam logic [SEL_W-1:0] RESET_IDX = SEL_W'(RESET_SEL);

   if (NUM_CLK < 2 || NUM_CLK > 16) begin : g_bad_num_clk
      $error("gfcm_n: NUM_CLK must be 2..16");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("gfcm_n: SYNC_STAGES must be 2..4");
   end
   if (RESET_SEL < 0 || RESET_SEL >= NUM_CLK) begin : g_bad_reset_sel
      $error("gfcm_n: RESET_SEL must index an existing channel");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("gfcm_n: TIMEOUT_CYCLES must be at least 2");
   end

   gfcm_state_e        state_q, state_d;
   logic [NUM_CLK-1:0] en_req_q, en_req_d;
   logic [NUM_CLK-1:0] en_ack;
   logic [NUM_CLK-1:0] gated_clk;
   logic [SEL_W-1:0]   target_q, target_d;
   logic [SEL_W-1:0]   active_sel_q, active_sel_d;
   logic               active_valid_q, active_valid_d;
   logic               sel_err_q, sel_err_d;

`ifdef GFCM_TIMEOUT_EN
   localparam int TMR_W = clog2_min1(TIMEOUT_CYCLES);
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             expired;
   logic             sel_timeout_q, sel_timeout_d;
`endif

   for (genvar gi = 0; gi < NUM_CLK; gi++) begin : g_chan
      gfcm_chan #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_chan (
         .clk1     (clk1),
         .reset    (reset),
         .clk_in   (clk_in[gi]),
         .en_req   (en_req_q[gi]),
         .en_ack   (en_ack[gi]),
         .gated_clk(gated_clk[gi])
      );
   end

   // At most one gate is open outside the switch gap, so a plain OR is the mux.
   assign outclk = |gated_clk;

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state_q        <= INIT;
         en_req_q       <= '0;
         target_q       <= RESET_IDX;
         active_sel_q   <= RESET_IDX;
         active_valid_q <= 1'b0;
         sel_err_q      <= 1'b0;
`ifdef GFCM_TIMEOUT_EN
         timer_q        <= '0;
         sel_timeout_q  <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         en_req_q       <= en_req_d;
         target_q       <= target_d;
         active_sel_q   <= active_sel_d;
         active_valid_q <= active_valid_d;
         sel_err_q      <= sel_err_d;
`ifdef GFCM_TIMEOUT_EN
         timer_q        <= timer_d;
         sel_timeout_q  <= sel_timeout_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      en_req_d       = en_req_q;
      target_d       = target_q;
      active_sel_d   = active_sel_q;
      active_valid_d = active_valid_q;
      sel_err_d      = 1'b0;
`ifdef GFCM_TIMEOUT_EN
      sel_timeout_d  = 1'b0;
      expired        = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`endif
      unique case (state_q)
         INIT: begin
            en_req_d = NUM_CLK'(1) << RESET_IDX;
            target_d = RESET_IDX;
            state_d  = EN_WAIT;
         end
         IDLE: begin
            if (sel_valid) begin
               if (int'(sel_data) >= NUM_CLK) begin
                  sel_err_d = 1'b1;
               end else if (!(active_valid_q && sel_data == active_sel_q)) begin
                  target_d       = sel_data;
                  en_req_d       = '0;
                  active_valid_d = 1'b0;
                  state_d        = DIS_WAIT;
               end
            end
         end
         DIS_WAIT: begin
            // Only enable the new channel once every gate is confirmed closed.
            if (en_ack == '0) begin
               en_req_d = NUM_CLK'(1) << target_q;
               state_d  = EN_WAIT;
            end
`ifdef GFCM_TIMEOUT_EN
            else if (expired) begin
               sel_timeout_d = 1'b1;
               en_req_d      = NUM_CLK'(1) << target_q;
               state_d       = EN_WAIT;
            end
`endif
         end
         EN_WAIT: begin
            if (en_ack[target_q]) begin
               active_sel_d   = target_q;
               active_valid_d = 1'b1;
               state_d        = IDLE;
            end
`ifdef GFCM_TIMEOUT_EN
            else if (expired) begin
               sel_timeout_d = 1'b1;
               en_req_d      = '0;
               state_d       = IDLE;
            end
`endif
         end
         default: state_d = INIT;
      endcase
`ifdef GFCM_TIMEOUT_EN
      // Restart on every state entry; only the two wait states ever count.
      if (state_d != state_q || state_q == IDLE || state_q == INIT) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end
`endif
   end

   always_comb begin
      sel_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
   end

   assign sel_err      = sel_err_q;
   assign active_sel   = active_sel_q;
   assign active_valid = active_valid_q;
`ifdef GFCM_TIMEOUT_EN
   assign sel_timeout  = sel_timeout_q;
`endif

endmodule

// File: tb/tb_gfcm_n.sv
// Bench for gfcm_n: directed selection requests push expected events into a queue,
// a clk1-falling-edge monitor pops and compares them as the DUT reports them.
module tb_gfcm_n;
   import gfcm_pkg::*;

   localparam int NUM_CLK        = 5;
   localparam int SYNC_STAGES    = 2;
   localparam int RESET_SEL      = 0;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int SEL_W          = clog2_min1(NUM_CLK);
   localparam int WAIT_CYC       = 400;
   localparam int EV_ERR         = 0;
   localparam int EV_DONE        = 1;
   localparam int EV_TMO         = 2;

   typedef struct {
      int kind;
      int sel;
   } exp_t;

   logic               clk1 = 1'b0;
   logic               reset = 1'b0;
   logic [NUM_CLK-1:0] clk_in;
   logic [NUM_CLK-1:0] run = '1;
   logic               sel_valid = 1'b0;
   logic [SEL_W-1:0]   sel_data = '0;
   logic               sel_ready, sel_err, active_valid, busy, outclk;
   logic [SEL_W-1:0]   active_sel;
`ifdef GFCM_TIMEOUT_EN
   logic               sel_timeout;
`endif

   exp_t    exp_q[$];
   int      checks = 0;
   int      errors = 0;
   int      glitches = 0;
   int      cyc = 0;
   int      ev_cyc = 0;
   logic    av_prev = 1'b0;
   realtime t_rise = 0;

   gfcm_n #(
      .NUM_CLK       (NUM_CLK),
      .SYNC_STAGES   (SYNC_STAGES),
      .RESET_SEL     (RESET_SEL),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk1        (clk1),
      .reset       (reset),
      .clk_in      (clk_in),
      .sel_valid   (sel_valid),
      .sel_data    (sel_data),
      .sel_ready   (sel_ready),
      .sel_err     (sel_err),
      .active_sel  (active_sel),
      .active_valid(active_valid),
      .busy        (busy),
`ifdef GFCM_TIMEOUT_EN
      .sel_timeout (sel_timeout),
`endif
      .outclk      (outclk)
   );

   // 40, 30, 20, 10 and 25 MHz candidate clocks.
   function automatic realtime half_t(input int i);
      case (i)
         0:       return 12.5ns;
         1:       return 16.667ns;
         2:       return 25ns;
         3:       return 50ns;
         default: return 20ns;
      endcase
   endfunction

   for (genvar gi = 0; gi < NUM_CLK; gi++) begin : g_clk
      logic c = 1'b0;
      always begin
         #(half_t(gi));
         if (run[gi]) c = ~c;
      end
      assign clk_in[gi] = c;
   end

   always #5ns clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   // Any outclk high pulse shorter than the fastest clock's high phase is a runt.
   always @(posedge outclk) t_rise <= $realtime;
   always @(negedge outclk) begin
      if (!reset && ($realtime - t_rise) < 12.4ns) glitches <= glitches + 1;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic observe(input int kind, input int sel);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event_kind", kind, -1);
         return;
      end
      e = exp_q.pop_front();
      $display("txn: event kind=%0d sel=%0d, expected kind=%0d sel=%0d", kind, sel, e.kind, e.sel);
      check("event_kind", kind, e.kind);
      if (e.kind == EV_DONE) check("event_active_sel", sel, e.sel);
   endtask

   always @(negedge clk1) begin
      if (!reset) begin
         if (sel_err) observe(EV_ERR, 0);
         if (active_valid && !av_prev) observe(EV_DONE, int'(active_sel));
`ifdef GFCM_TIMEOUT_EN
         if (sel_timeout) begin
            ev_cyc = cyc;
            observe(EV_TMO, 0);
         end
`endif
      end
      av_prev <= active_valid;
   end

   task automatic push(input int kind, input int sel);
      exp_t e;
      e.kind = kind;
      e.sel  = sel;
      exp_q.push_back(e);
   endtask

   // Called at a clk1 falling edge; returns at the falling edge after the transfer.
   task automatic send(input int idx, output int waited);
      waited    = 0;
      sel_valid = 1'b1;
      sel_data  = SEL_W'(idx);
      while (!sel_ready && waited < WAIT_CYC) begin
         @(negedge clk1);
         waited++;
      end
      check("handshake_ready", int'(sel_ready), 1);
      @(negedge clk1);
      sel_valid = 1'b0;
      $display("txn: request sel_data=%0d accepted after %0d wait cycles", idx, waited);
   endtask

   task automatic wait_events(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < WAIT_CYC) begin
         @(negedge clk1);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // outclk must equal the chosen input clock just after each of its edges.
   task automatic follow(input int k, input string name);
      int bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(clk_in[k]);
         #1ns;
         if (outclk !== clk_in[k]) bad++;
      end
      check(name, bad, 0);
      @(negedge clk1);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int bad;
      #1ns reset = 1'b1;
      repeat (3) @(negedge clk1);
      check("reset_sel_ready", int'(sel_ready), 0);
      check("reset_sel_err", int'(sel_err), 0);
      check("reset_busy", int'(busy), 1);
      check("reset_active_valid", int'(active_valid), 0);
      check("reset_active_sel", int'(active_sel), RESET_SEL);
      check("reset_outclk", int'(outclk), 0);

      push(EV_DONE, RESET_SEL);
      reset = 1'b0;
      wait_events("init_done");
      check("init_busy", int'(busy), 0);
      check("init_sel_ready", int'(sel_ready), 1);
      follow(0, "follow_clk0");

      // Switch 0 -> 2
      push(EV_DONE, 2);
      send(2, w);
      check("switch_busy", int'(busy), 1);
      check("switch_active_valid", int'(active_valid), 0);
      wait_events("switch2_done");
      follow(2, "follow_clk2");
      check("no_runt_switch2", glitches, 0);

      // Out-of-range indices
      push(EV_ERR, 0);
      send(5, w);
      push(EV_ERR, 0);
      send(7, w);
      wait_events("sel_err_events");
      check("err_active_sel", int'(active_sel), 2);
      check("err_active_valid", int'(active_valid), 1);
      check("err_busy", int'(busy), 0);

      // Re-select the active channel: no switch
      send(2, w);
      check("same_sel_immediate", w, 0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk1);
         if (busy || !active_valid) bad++;
      end
      check("same_sel_no_switch", bad, 0);
      follow(2, "follow_clk2_same");

      // Switch 2 -> 1
      push(EV_DONE, 1);
      send(1, w);
      wait_events("switch1_done");
      follow(1, "follow_clk1");
      check("no_runt_switch1", glitches, 0);

      // Reset while disabling the old channel
      send(3, w);
      check("abort_busy", int'(busy), 1);
      #2ns reset = 1'b1;
      #1ns;
      check("abort_outclk", int'(outclk), 0);
      check("abort_sel_ready", int'(sel_ready), 0);
      check("abort_active_valid", int'(active_valid), 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         #3ns;
         if (outclk !== 1'b0) bad++;
      end
      check("abort_outclk_held_low", bad, 0);
      @(negedge clk1);
      push(EV_DONE, RESET_SEL);
      reset = 1'b0;
      wait_events("recover_done");
      follow(RESET_SEL, "follow_recover");

`ifdef GFCM_TIMEOUT_EN
      // Dead target clock: EN_WAIT must give up
      run[3] = 1'b0;
      repeat (2) @(negedge clk1);
      push(EV_TMO, 0);
      send(3, w);
      w = cyc;
      wait_events("timeout_event");
      @(negedge clk1);
      check("timeout_latency_ok", int'((ev_cyc - w) >= 65 && (ev_cyc - w) <= 110), 1);
      check("timeout_active_valid", int'(active_valid), 0);
      check("timeout_sel_ready", int'(sel_ready), 1);
      check("timeout_busy", int'(busy), 0);
      check("timeout_outclk_low", int'(outclk), 0);
      run[3] = 1'b1;
      push(EV_DONE, 1);
      send(1, w);
      wait_events("after_timeout_done");
      follow(1, "follow_after_timeout");
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      check("no_runt_pulses", glitches, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
